// File: rtl/screen_switch_ctrl.sv
// rtl/screen_switch_ctrl.sv - OLED source switcher: holds the old picture until a frame boundary,
// then outputs black frames and pulses a restart to the new source before routing it.
module screen_switch_ctrl #(
  parameter int BLANK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic        frame_begin,
  input  logic [15:0] pix_menu,
  input  logic [15:0] pix_vol,
  input  logic [15:0] pix_poke,
  input  logic [15:0] pix_fruit,
  input  logic [15:0] pix_potion,
  output logic [15:0] oled_data,
  output logic [2:0]  active_src,
  output logic        switching,
  output logic [4:0]  src_rst
);

  typedef enum logic [1:0] {SHOW, WAIT_FRAME, BLANK, RESTART} fsm_t;

  localparam logic [3:0] LAST_BLANK = 4'(BLANK_FRAMES - 1);

  fsm_t        fsm, fsm_next;
  logic [2:0]  target;
  logic [2:0]  pend_src, pend_next;
  logic [2:0]  active_next;
  logic [3:0]  blank_cnt, cnt_next;
  logic        show_pix;
  logic [15:0] sel_pix;

  always_comb begin
    case (state)
      4'b0000:                   target = 3'd0;
      4'b0001:                   target = 3'd1;
      4'b0010, 4'b0011:          target = 3'd2;
      4'b0100:                   target = 3'd3;
      4'b0101, 4'b0110, 4'b0111: target = 3'd4;
      default:                   target = 3'd0;
    endcase
  end

  always_comb begin
    case (active_src)
      3'd1:    sel_pix = pix_vol;
      3'd2:    sel_pix = pix_poke;
      3'd3:    sel_pix = pix_fruit;
      3'd4:    sel_pix = pix_potion;
      default: sel_pix = pix_menu;
    endcase
  end

  always_comb begin
    fsm_next    = fsm;
    pend_next   = pend_src;
    cnt_next    = blank_cnt;
    active_next = active_src;
    show_pix    = 1'b0;
    src_rst     = 5'b00000;
    case (fsm)
      SHOW: begin
        show_pix = 1'b1;
        if (target != active_src) begin
          pend_next = target;
          fsm_next  = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        pend_next = target;
        // Pixel 0 of the frame that starts now is already black, so no frame is torn.
        if (frame_begin) begin
          fsm_next = BLANK;
          cnt_next = 4'd0;
        end else begin
          show_pix = 1'b1;
        end
      end
      BLANK: begin
        // A retarget restarts the blank period and swallows a coincident frame_begin.
        if (target != pend_src) begin
          pend_next = target;
          cnt_next  = 4'd0;
        end else if (frame_begin) begin
          if (blank_cnt == LAST_BLANK) begin
            fsm_next = RESTART;
          end else if (blank_cnt != 4'hF) begin
            cnt_next = blank_cnt + 4'd1;
          end
        end
      end
      RESTART: begin
        active_next = pend_src;
        src_rst     = 5'b00001 << pend_src;
        fsm_next    = SHOW;
      end
      default: fsm_next = SHOW;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm        <= SHOW;
      active_src <= 3'd0;
      pend_src   <= 3'd0;
      blank_cnt  <= 4'd0;
      oled_data  <= 16'h0000;
    end else begin
      fsm        <= fsm_next;
      active_src <= active_next;
      pend_src   <= pend_next;
      blank_cnt  <= cnt_next;
      oled_data  <= show_pix ? sel_pix : 16'h0000;
    end
  end

  assign switching = (fsm != SHOW);

endmodule

// File: tb/tb_screen_switch_ctrl.sv
// tb/tb_screen_switch_ctrl.sv - scoreboard bench for screen_switch_ctrl.
module tb_screen_switch_ctrl;
  localparam int BF = 2;
  localparam int FP = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic        frame_begin;
  logic [15:0] pix_menu, pix_vol, pix_poke, pix_fruit, pix_potion;
  logic [15:0] oled_data;
  logic [2:0]  active_src;
  logic        switching;
  logic [4:0]  src_rst;

  always #5 clk = ~clk;

  screen_switch_ctrl #(.BLANK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .state(state), .frame_begin(frame_begin),
    .pix_menu(pix_menu), .pix_vol(pix_vol), .pix_poke(pix_poke),
    .pix_fruit(pix_fruit), .pix_potion(pix_potion),
    .oled_data(oled_data), .active_src(active_src),
    .switching(switching), .src_rst(src_rst)
  );

  typedef struct packed {
    logic [15:0] oled;
    logic        sw;
    logic [4:0]  rst;
    logic [2:0]  act;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  me;
  int    tests = 0;
  int    fails = 0;
  string tname = "init";
  logic  rst_drv = 1'b1;

  function automatic logic [15:0] pix_of(input logic [2:0] s);
    case (s)
      3'd0:    return pix_menu;
      3'd1:    return pix_vol;
      3'd2:    return pix_poke;
      3'd3:    return pix_fruit;
      3'd4:    return pix_potion;
      default: return 16'h0000;
    endcase
  endfunction

  // One clock of stimulus; expectations describe the outputs after the coming rising edge.
  task automatic cyc(input logic [3:0] st, input logic fb, input logic vis, input logic [2:0] vsrc,
                     input logic sw, input logic [4:0] sr, input logic [2:0] act);
    exp_t e;
    @(negedge clk);
    reset       = rst_drv;
    state       = st;
    frame_begin = fb;
    pix_menu    = 16'($urandom_range(1, 65535));
    pix_vol     = 16'($urandom_range(1, 65535));
    pix_poke    = 16'($urandom_range(1, 65535));
    pix_fruit   = 16'($urandom_range(1, 65535));
    pix_potion  = 16'($urandom_range(1, 65535));
    e.oled = vis ? pix_of(vsrc) : 16'h0000;
    e.sw   = sw;
    e.rst  = sr;
    e.act  = act;
    exp_q.push_back(e);
  endtask

  task automatic span(input logic [3:0] st, input int n, input logic vis, input logic [2:0] vsrc,
                      input logic sw, input logic [2:0] act);
    repeat (n) cyc(st, 1'b0, vis, vsrc, sw, 5'b00000, act);
  endtask

  always @(posedge clk) begin
    #3;
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      tests += 4;
      if (oled_data !== me.oled) begin
        fails++;
        $display("FAIL %s oled_data: got %h expected %h", tname, oled_data, me.oled);
      end
      if (switching !== me.sw) begin
        fails++;
        $display("FAIL %s switching: got %b expected %b", tname, switching, me.sw);
      end
      if (src_rst !== me.rst) begin
        fails++;
        $display("FAIL %s src_rst: got %b expected %b", tname, src_rst, me.rst);
      end
      if (active_src !== me.act) begin
        fails++;
        $display("FAIL %s active_src: got %0d expected %0d", tname, active_src, me.act);
      end
    end
  end

  task automatic do_switch(input logic [3:0] st, input logic [2:0] old_src, input logic [2:0] new_src);
    cyc(st, 1'b0, 1'b1, old_src, 1'b1, 5'b00000, old_src);
    span(st, FP - 2, 1'b1, old_src, 1'b1, old_src);
    cyc(st, 1'b1, 1'b0, old_src, 1'b1, 5'b00000, old_src);
    for (int f = 1; f < BF; f++) begin
      span(st, FP - 1, 1'b0, old_src, 1'b1, old_src);
      cyc(st, 1'b1, 1'b0, old_src, 1'b1, 5'b00000, old_src);
    end
    span(st, FP - 1, 1'b0, old_src, 1'b1, old_src);
    cyc(st, 1'b1, 1'b0, old_src, 1'b1, 5'b00001 << new_src, old_src);
    cyc(st, 1'b0, 1'b0, old_src, 1'b0, 5'b00000, new_src);
    cyc(st, 1'b0, 1'b1, new_src, 1'b0, 5'b00000, new_src);
  endtask

  task automatic test_reset();
    tname = "reset";
    reset = 1'b1; state = 4'b0000; frame_begin = 1'b0;
    pix_menu = 16'hF800; pix_vol = 16'h07E0; pix_poke = 16'h001F;
    pix_fruit = 16'hFFFF; pix_potion = 16'h1234;
    #1;
    tests++;
    if ({oled_data, switching, src_rst, active_src} !== 25'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h/%b/%b/%0d expected 0/0/0/0",
               oled_data, switching, src_rst, active_src);
    end
    rst_drv = 1'b1;
    repeat (3) cyc(4'b0001, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd0);
    rst_drv = 1'b0;
  endtask

  task automatic test_steady_menu();
    tname = "steady_menu";
    span(4'b0000, 10, 1'b1, 3'd0, 1'b0, 3'd0);
    cyc(4'b0000, 1'b1, 1'b1, 3'd0, 1'b0, 5'b00000, 3'd0);
    span(4'b0000, 10, 1'b1, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic test_normal_switch();
    tname = "normal_switch";
    do_switch(4'b0001, 3'd0, 3'd1);
    span(4'b0001, 5, 1'b1, 3'd1, 1'b0, 3'd1);
  endtask

  task automatic test_same_source();
    tname = "same_source_setup";
    do_switch(4'b0010, 3'd1, 3'd2);
    tname = "same_source";
    for (int i = 0; i < 30; i++)
      cyc((i % 2 == 1) ? 4'b0011 : 4'b0010, i == 10, 1'b1, 3'd2, 1'b0, 5'b00000, 3'd2);
  endtask

  task automatic test_retarget_blank();
    tname = "retarget_setup";
    do_switch(4'b0000, 3'd2, 3'd0);
    tname = "retarget_blank";
    cyc(4'b0100, 1'b0, 1'b1, 3'd0, 1'b1, 5'b00000, 3'd0);
    span(4'b0100, FP - 2, 1'b1, 3'd0, 1'b1, 3'd0);
    cyc(4'b0100, 1'b1, 1'b0, 3'd0, 1'b1, 5'b00000, 3'd0);
    span(4'b0100, FP - 1, 1'b0, 3'd0, 1'b1, 3'd0);
    cyc(4'b0100, 1'b1, 1'b0, 3'd0, 1'b1, 5'b00000, 3'd0);
    span(4'b0100, 10, 1'b0, 3'd0, 1'b1, 3'd0);
    cyc(4'b0110, 1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 3'd0);
    span(4'b0110, FP - 12, 1'b0, 3'd0, 1'b1, 3'd0);
    cyc(4'b0110, 1'b1, 1'b0, 3'd0, 1'b1, 5'b00000, 3'd0);
    span(4'b0110, FP - 1, 1'b0, 3'd0, 1'b1, 3'd0);
    cyc(4'b0110, 1'b1, 1'b0, 3'd0, 1'b1, 5'b10000, 3'd0);
    cyc(4'b0110, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd4);
    cyc(4'b0110, 1'b0, 1'b1, 3'd4, 1'b0, 5'b00000, 3'd4);
  endtask

  task automatic test_collision();
    tname = "collision";
    cyc(4'b0001, 1'b0, 1'b1, 3'd4, 1'b1, 5'b00000, 3'd4);
    span(4'b0001, FP - 2, 1'b1, 3'd4, 1'b1, 3'd4);
    cyc(4'b0001, 1'b1, 1'b0, 3'd4, 1'b1, 5'b00000, 3'd4);
    span(4'b0001, FP - 1, 1'b0, 3'd4, 1'b1, 3'd4);
    cyc(4'b0010, 1'b1, 1'b0, 3'd4, 1'b1, 5'b00000, 3'd4);
    span(4'b0010, FP - 1, 1'b0, 3'd4, 1'b1, 3'd4);
    cyc(4'b0010, 1'b1, 1'b0, 3'd4, 1'b1, 5'b00000, 3'd4);
    span(4'b0010, FP - 1, 1'b0, 3'd4, 1'b1, 3'd4);
    cyc(4'b0010, 1'b1, 1'b0, 3'd4, 1'b1, 5'b00100, 3'd4);
    cyc(4'b0010, 1'b0, 1'b0, 3'd4, 1'b0, 5'b00000, 3'd2);
    cyc(4'b0010, 1'b0, 1'b1, 3'd2, 1'b0, 5'b00000, 3'd2);
  endtask

  task automatic test_return_to_active();
    tname = "return_to_active";
    cyc(4'b0000, 1'b0, 1'b1, 3'd2, 1'b1, 5'b00000, 3'd2);
    span(4'b0000, FP - 2, 1'b1, 3'd2, 1'b1, 3'd2);
    cyc(4'b0000, 1'b1, 1'b0, 3'd2, 1'b1, 5'b00000, 3'd2);
    span(4'b0000, 5, 1'b0, 3'd2, 1'b1, 3'd2);
    cyc(4'b0010, 1'b0, 1'b0, 3'd2, 1'b1, 5'b00000, 3'd2);
    span(4'b0010, FP - 7, 1'b0, 3'd2, 1'b1, 3'd2);
    cyc(4'b0010, 1'b1, 1'b0, 3'd2, 1'b1, 5'b00000, 3'd2);
    span(4'b0010, FP - 1, 1'b0, 3'd2, 1'b1, 3'd2);
    cyc(4'b0010, 1'b1, 1'b0, 3'd2, 1'b1, 5'b00100, 3'd2);
    cyc(4'b0010, 1'b0, 1'b0, 3'd2, 1'b0, 5'b00000, 3'd2);
    cyc(4'b0010, 1'b0, 1'b1, 3'd2, 1'b0, 5'b00000, 3'd2);
  endtask

  task automatic test_reset_mid_blank();
    tname = "reset_mid_blank";
    cyc(4'b0100, 1'b0, 1'b1, 3'd2, 1'b1, 5'b00000, 3'd2);
    span(4'b0100, FP - 2, 1'b1, 3'd2, 1'b1, 3'd2);
    cyc(4'b0100, 1'b1, 1'b0, 3'd2, 1'b1, 5'b00000, 3'd2);
    span(4'b0100, 20, 1'b0, 3'd2, 1'b1, 3'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({oled_data, switching, src_rst, active_src} !== 25'd0) begin
      fails++;
      $display("FAIL reset_mid_blank_immediate: got %h/%b/%b/%0d expected 0/0/0/0",
               oled_data, switching, src_rst, active_src);
    end
    rst_drv = 1'b1;
    cyc(4'b0100, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd0);
    cyc(4'b0100, 1'b1, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd0);
    cyc(4'b0100, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd0);
    rst_drv = 1'b0;
    tname = "reset_release_switch";
    do_switch(4'b0100, 3'd0, 3'd3);
  endtask

  initial begin
    test_reset();
    test_steady_menu();
    test_normal_switch();
    test_same_source();
    test_retarget_blank();
    test_collision();
    test_return_to_active();
    test_reset_mid_blank();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
